// File: rtl/vscale_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vscale_mem_arbiter_pkg
// Shared definitions for the imem/dmem memory-port arbiter:
//   - arb_owner_t : owner of the outstanding data phase (none, fetch, load/store)
//   - MEM_TYPE_W  : word access size in the codebase memory-size encoding
//   - burst_ctr_width() : width of the fetch-starvation counter for a given
//                         burst limit (never narrower than one bit)
// -----------------------------------------------------------------------------
package vscale_mem_arbiter_pkg;

  localparam int MEM_SIZE_WIDTH = 3;

  // Word size, same code the rest of the core uses for 32-bit accesses.
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_TYPE_W = 3'd2;

  typedef enum logic [1:0] {
    ARB_OWNER_NONE = 2'd0,
    ARB_OWNER_IMEM = 2'd1,
    ARB_OWNER_DMEM = 2'd2
  } arb_owner_t;

  // Counter must be able to hold the value burst itself.
  function automatic int burst_ctr_width(input int burst);
    return (burst < 1) ? 1 : $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/vscale_arb_burst_ctr.sv
// -----------------------------------------------------------------------------
// vscale_arb_burst_ctr
// Counts consecutive accepted dmem grants while a fetch is waiting and raises
// force_i once DMEM_BURST of them have gone by, so the fetch wins the next
// arbitration. DMEM_BURST = 0 disables the guard (strict dmem priority).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   imem_en      : fetch request pending
//   accept_d     : dmem grant accepted this cycle (already excludes stalls)
//   accept_i     : imem grant accepted this cycle (already excludes stalls)
//   force_i      : fetch must be granted this cycle
// -----------------------------------------------------------------------------
module vscale_arb_burst_ctr
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int DMEM_BURST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic imem_en,
  input  logic accept_d,
  input  logic accept_i,
  output logic force_i
);

  localparam int CW = burst_ctr_width(DMEM_BURST);
  localparam logic [CW-1:0] BURST_MAX = CW'(DMEM_BURST);

  logic [CW-1:0] burst_reg;
  logic [CW-1:0] burst_next;

  // With DMEM_BURST = 0 the saturation limit is 0, so the counter never moves
  // and force_i stays low.
  always_comb begin
    burst_next = burst_reg;
    if (!imem_en || accept_i) begin
      burst_next = '0;
    end else if (accept_d && (burst_reg != BURST_MAX)) begin
      burst_next = burst_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_reg <= '0;
    end else begin
      burst_reg <= burst_next;
    end
  end

  assign force_i = imem_en && (DMEM_BURST != 0) && (burst_reg == BURST_MAX);

endmodule

// File: rtl/vscale_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vscale_mem_arbiter
// Shares one two-phase (address, then data) memory port between the fetch
// (imem) and load/store (dmem) interfaces. dmem wins by default; a burst
// counter lets a waiting fetch through after DMEM_BURST dmem grants. The
// owner of the outstanding data phase is registered so read data, write
// data, wait and bad-memory status reach that owner only.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   imem_*                : fetch request (en, addr) / response (rdata, wait,
//                           badmem_e)
//   dmem_*                : load/store request (en, wen, size, addr,
//                           wdata_delayed in the data phase) / response
//   mem_*                 : shared memory port; en/wen/size/addr form the
//                           address phase, wdata/rdata/wait/badmem_e the
//                           data phase
// -----------------------------------------------------------------------------
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int DMEM_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // fetch side
  input  logic        imem_en,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_wait,
  output logic        imem_badmem_e,
  // load/store side
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e,
  // shared memory port
  output logic        mem_en,
  output logic        mem_wen,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_wait,
  input  logic        mem_badmem_e
);

  arb_owner_t owner_reg;
  arb_owner_t owner_next;
  logic       wen_reg;
  logic       wen_next;

  logic stall;
  logic force_i;
  logic grant_d;
  logic grant_i;

  // mem_wait only matters while someone owns a data phase.
  assign stall = mem_wait && (owner_reg != ARB_OWNER_NONE);

  assign grant_d = !stall && dmem_en && !force_i;
  assign grant_i = !stall && imem_en && !grant_d;

  vscale_arb_burst_ctr #(
    .DMEM_BURST (DMEM_BURST)
  ) u_burst_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .imem_en  (imem_en),
    .accept_d (grant_d),
    .accept_i (grant_i),
    .force_i  (force_i)
  );

  // Address phase: issued in the same cycle the request is seen.
  always_comb begin
    mem_en   = grant_d || grant_i;
    mem_wen  = 1'b0;
    mem_size = '0;
    mem_addr = '0;
    if (grant_d) begin
      mem_wen  = dmem_wen;
      mem_size = dmem_size;
      mem_addr = dmem_addr;
    end else if (grant_i) begin
      mem_size = MEM_TYPE_W;
      mem_addr = imem_addr;
    end
  end

  // The granted side owns the next data phase; a stalled data phase keeps
  // its owner until mem_wait drops.
  always_comb begin
    owner_next = owner_reg;
    wen_next   = wen_reg;
    if (!stall) begin
      wen_next = grant_d && dmem_wen;
      if (grant_d) begin
        owner_next = ARB_OWNER_DMEM;
      end else if (grant_i) begin
        owner_next = ARB_OWNER_IMEM;
      end else begin
        owner_next = ARB_OWNER_NONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_reg <= ARB_OWNER_NONE;
      wen_reg   <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      wen_reg   <= wen_next;
    end
  end

  // A side waits if it asked and lost (stall included) or if it owns a data
  // phase that memory is extending.
  assign imem_wait = (imem_en && !grant_i) ||
                     ((owner_reg == ARB_OWNER_IMEM) && mem_wait);
  assign dmem_wait = (dmem_en && !grant_d) ||
                     ((owner_reg == ARB_OWNER_DMEM) && mem_wait);

  // Data phase routing.
  assign mem_wdata     = ((owner_reg == ARB_OWNER_DMEM) && wen_reg) ? dmem_wdata_delayed : 32'd0;
  assign imem_rdata    = (owner_reg == ARB_OWNER_IMEM) ? mem_rdata : 32'd0;
  assign dmem_rdata    = (owner_reg == ARB_OWNER_DMEM) ? mem_rdata : 32'd0;
  assign imem_badmem_e = (owner_reg == ARB_OWNER_IMEM) && mem_badmem_e;
  assign dmem_badmem_e = (owner_reg == ARB_OWNER_DMEM) && mem_badmem_e;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter. Two instances share all inputs:
// index 0 uses DMEM_BURST = 4, index 1 uses DMEM_BURST = 0. A behavioural
// model of each instance is checked against the outputs at every negedge,
// and hand-computed literals pin the model in the directed scenarios.
module tb_vscale_mem_arbiter;

  localparam int LIM0 = 4;
  localparam int LIM1 = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] mem_rdata;
  logic        mem_wait;
  logic        mem_badmem_e;

  logic [31:0] imem_rdata_o [2];
  logic [31:0] dmem_rdata_o [2];
  logic [31:0] mem_addr_o   [2];
  logic [31:0] mem_wdata_o  [2];
  logic [2:0]  mem_size_o   [2];
  logic [1:0]  imem_wait_o, imem_bad_o, dmem_wait_o, dmem_bad_o, mem_en_o, mem_wen_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vscale_mem_arbiter #(.DMEM_BURST(LIM0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata_o[0]),
    .imem_wait(imem_wait_o[0]), .imem_badmem_e(imem_bad_o[0]),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_rdata(dmem_rdata_o[0]),
    .dmem_wait(dmem_wait_o[0]), .dmem_badmem_e(dmem_bad_o[0]),
    .mem_en(mem_en_o[0]), .mem_wen(mem_wen_o[0]), .mem_size(mem_size_o[0]),
    .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata),
    .mem_wait(mem_wait), .mem_badmem_e(mem_badmem_e)
  );

  vscale_mem_arbiter #(.DMEM_BURST(LIM1)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata_o[1]),
    .imem_wait(imem_wait_o[1]), .imem_badmem_e(imem_bad_o[1]),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_rdata(dmem_rdata_o[1]),
    .dmem_wait(dmem_wait_o[1]), .dmem_badmem_e(dmem_bad_o[1]),
    .mem_en(mem_en_o[1]), .mem_wen(mem_wen_o[1]), .mem_size(mem_size_o[1]),
    .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata),
    .mem_wait(mem_wait), .mem_badmem_e(mem_badmem_e)
  );

  // ---------------------------------------------------------------- model
  // Owner: 0 none, 1 fetch, 2 load/store. run = dmem wins since the fetch
  // last got through (or last went idle).
  int   m_own [2] = '{0, 0};
  logic m_wen [2] = '{1'b0, 1'b0};
  int   m_run [2] = '{0, 0};

  typedef struct packed {
    logic        stall;
    logic        gi;
    logic        gd;
    logic        mem_en;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic        imem_wait;
    logic        dmem_wait;
    logic [31:0] mem_wdata;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_rdata;
    logic        imem_bad;
    logic        dmem_bad;
  } exp_t;

  function automatic int limit_of(input int k);
    return (k == 0) ? LIM0 : LIM1;
  endfunction

  function automatic exp_t model(input int k);
    exp_t e;
    logic turn;
    int   lim;
    lim     = limit_of(k);
    e       = '0;
    e.stall = mem_wait && (m_own[k] != 0);
    turn    = imem_en && (lim > 0) && (m_run[k] >= lim);
    e.gd    = !e.stall && dmem_en && !turn;
    e.gi    = !e.stall && imem_en && !e.gd;
    e.mem_en = e.gd || e.gi;
    if (e.gd) begin
      e.mem_wen  = dmem_wen;
      e.mem_size = dmem_size;
      e.mem_addr = dmem_addr;
    end else if (e.gi) begin
      e.mem_size = 3'd2;
      e.mem_addr = imem_addr;
    end
    e.imem_wait  = (imem_en && !e.gi) || (m_own[k] == 1 && mem_wait);
    e.dmem_wait  = (dmem_en && !e.gd) || (m_own[k] == 2 && mem_wait);
    e.mem_wdata  = (m_own[k] == 2 && m_wen[k]) ? dmem_wdata_delayed : 32'd0;
    e.imem_rdata = (m_own[k] == 1) ? mem_rdata : 32'd0;
    e.dmem_rdata = (m_own[k] == 2) ? mem_rdata : 32'd0;
    e.imem_bad   = (m_own[k] == 1) && mem_badmem_e;
    e.dmem_bad   = (m_own[k] == 2) && mem_badmem_e;
    return e;
  endfunction

  function automatic int nxt_own(input int k);
    exp_t e;
    e = model(k);
    if (e.stall) return m_own[k];
    return e.gd ? 2 : (e.gi ? 1 : 0);
  endfunction

  function automatic logic nxt_wen(input int k);
    exp_t e;
    e = model(k);
    if (e.stall) return m_wen[k];
    return e.gd && dmem_wen;
  endfunction

  function automatic int nxt_run(input int k);
    exp_t e;
    e = model(k);
    if (!imem_en || e.gi) return 0;
    if (e.gd) return (m_run[k] + 1 > limit_of(k)) ? limit_of(k) : m_run[k] + 1;
    return m_run[k];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_own[k] <= 0;
        m_wen[k] <= 1'b0;
        m_run[k] <= 0;
      end else begin
        m_own[k] <= nxt_own(k);
        m_wen[k] <= nxt_wen(k);
        m_run[k] <= nxt_run(k);
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [36:0] ga, ge;
    logic [1:0]  wa, we;
    logic [97:0] da, de;
    for (int k = 0; k < 2; k++) begin
      e  = model(k);
      ga = {mem_en_o[k], mem_wen_o[k], mem_size_o[k], mem_addr_o[k]};
      ge = {e.mem_en, e.mem_wen, e.mem_size, e.mem_addr};
      wa = {imem_wait_o[k], dmem_wait_o[k]};
      we = {e.imem_wait, e.dmem_wait};
      da = {mem_wdata_o[k], imem_rdata_o[k], dmem_rdata_o[k], imem_bad_o[k], dmem_bad_o[k]};
      de = {e.mem_wdata, e.imem_rdata, e.dmem_rdata, e.imem_bad, e.dmem_bad};
      n_vec++;
      if (ga !== ge) begin
        n_bad++;
        $display("FAIL addr_phase inst%0d t=%0t: got en/wen/size/addr=%h, want %h", k, $time, ga, ge);
      end
      n_vec++;
      if (wa !== we) begin
        n_bad++;
        $display("FAIL waits inst%0d t=%0t: got imem/dmem wait=%b, want %b", k, $time, wa, we);
      end
      n_vec++;
      if (da !== de) begin
        n_bad++;
        $display("FAIL data_phase inst%0d t=%0t: got wdata/irdata/drdata/bad=%h, want %h", k, $time, da, de);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  function automatic logic any_out0();
    return |{mem_en_o[0], mem_wen_o[0], mem_size_o[0], mem_addr_o[0], mem_wdata_o[0],
             imem_rdata_o[0], dmem_rdata_o[0], imem_wait_o[0], dmem_wait_o[0],
             imem_bad_o[0], dmem_bad_o[0]};
  endfunction

  // ---------------------------------------------------------------- stimulus
  logic [9:0] pat0, pat1;
  int         wd_cnt, dw_cnt, en_cnt;

  initial begin
    reset_n = 1'b0; imem_en = 1'b0; imem_addr = '0; dmem_en = 1'b0; dmem_wen = 1'b0;
    dmem_size = 3'd2; dmem_addr = '0; dmem_wdata_delayed = '0; mem_rdata = '0;
    mem_wait = 1'b0; mem_badmem_e = 1'b0;
    tick(); tick();
    #2 chk("reset_all_zero", any_out0(), 0);
    reset_n = 1'b1;
    tick();

    // reset in the middle of a stalled dmem data phase
    dmem_en = 1'b1; dmem_addr = 32'h80;
    #2 chk("rst_load_issue", mem_en_o[0], 1);
    tick();
    dmem_en = 1'b0; mem_wait = 1'b1; mem_rdata = 32'h55AA55AA;
    #2 chk("rst_stall_dwait", dmem_wait_o[0], 1);
    chk("rst_stall_no_en", mem_en_o[0], 0);
    reset_n = 1'b0;
    #1 chk("rst_async_dwait", dmem_wait_o[0], 0);
    chk("rst_async_rdata", dmem_rdata_o[0], 0);
    tick();
    reset_n = 1'b1;
    #2 chk("rst_release_zero", any_out0(), 0);
    tick();
    mem_wait = 1'b0; mem_rdata = '0; imem_en = 1'b1; imem_addr = 32'h0;
    #2 chk("post_rst_fetch_en", mem_en_o[0], 1);
    chk("post_rst_fetch_addr", mem_addr_o[0], 32'h0);
    chk("post_rst_fetch_size", mem_size_o[0], 32'd2);
    tick();

    // simultaneous requests
    imem_addr = 32'h100; dmem_en = 1'b1; dmem_addr = 32'h2000;
    #2 chk("sim_n_addr", mem_addr_o[0], 32'h2000);
    chk("sim_n_iwait", imem_wait_o[0], 1);
    chk("sim_n_dwait", dmem_wait_o[0], 0);
    tick();
    dmem_en = 1'b0; mem_rdata = 32'hDEADBEEF;
    #2 chk("sim_n1_drdata", dmem_rdata_o[0], 32'hDEADBEEF);
    chk("sim_n1_irdata", imem_rdata_o[0], 0);
    chk("sim_n1_addr", mem_addr_o[0], 32'h100);
    tick();
    imem_en = 1'b0; mem_rdata = 32'hCAFEF00D;
    #2 chk("sim_n2_irdata", imem_rdata_o[0], 32'hCAFEF00D);
    chk("sim_n2_drdata", dmem_rdata_o[0], 0);
    tick();

    // store with two wait cycles, fetch pending behind it
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h40; dmem_wdata_delayed = 32'h12345678;
    imem_en = 1'b1; imem_addr = 32'h200;
    #2 chk("st_wen", mem_wen_o[0], 1);
    chk("st_addr", mem_addr_o[0], 32'h40);
    chk("st_iwait", imem_wait_o[0], 1);
    tick();
    wd_cnt = 0; dw_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_en = 1'b0; dmem_wen = 1'b0; mem_wait = (i < 2);
      #2;
      if (mem_wdata_o[0] == 32'h12345678) wd_cnt++;
      if (dmem_wait_o[0]) dw_cnt++;
      if (i < 2) chk("st_stall_no_en", mem_en_o[0], 0);
      else chk("st_fetch_after", mem_addr_o[0], 32'h200);
      tick();
    end
    chk("st_wdata_cycles", wd_cnt, 3);
    chk("st_dwait_cycles", dw_cnt, 2);
    mem_wait = 1'b0; imem_en = 1'b0;
    tick();

    // starvation guard: both requests continuously high
    pat0 = '0; pat1 = '0;
    for (int i = 0; i < 10; i++) begin
      dmem_en = 1'b1; dmem_addr = 32'h3000 + 32'(i * 4); imem_en = 1'b1; imem_addr = 32'h400;
      #2;
      pat0[i] = (mem_addr_o[0] == 32'h400);
      pat1[i] = (mem_addr_o[1] == 32'h400);
      tick();
    end
    chk("burst4_pattern", 32'(pat0), 32'h210);
    chk("burst0_pattern", 32'(pat1), 32'h0);

    // bad memory on a fetch data phase
    dmem_en = 1'b0; imem_en = 1'b1; imem_addr = 32'h500;
    #2 chk("bad_fetch_addr", mem_addr_o[0], 32'h500);
    tick();
    imem_en = 1'b0; dmem_en = 1'b1; dmem_addr = 32'h600; mem_badmem_e = 1'b1; mem_rdata = 32'h0BAD0BAD;
    #2 chk("bad_imem_flag", imem_bad_o[0], 1);
    chk("bad_dmem_flag", dmem_bad_o[0], 0);
    chk("bad_next_addr", mem_addr_o[0], 32'h600);
    tick();
    dmem_en = 1'b0;
    #2 chk("bad_dmem_owner", dmem_bad_o[0], 1);
    chk("bad_imem_clear", imem_bad_o[0], 0);
    tick();
    mem_badmem_e = 1'b0;

    // back-to-back alternating load / fetch
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      dmem_en = (i % 2 == 0); imem_en = (i % 2 == 1);
      dmem_addr = 32'h1000 + 32'(i * 4); imem_addr = 32'h8000 + 32'(i * 4);
      mem_rdata = 32'hA0000000 + 32'(i);
      #2;
      en_cnt += int'(mem_en_o[0]);
      if (i > 0) begin
        if (i % 2 == 1) chk("b2b_to_dmem", dmem_rdata_o[0], 32'hA0000000 + 32'(i));
        else chk("b2b_to_imem", imem_rdata_o[0], 32'hA0000000 + 32'(i));
      end
      tick();
    end
    chk("b2b_issue_count", en_cnt, 8);

    // mixed traffic, model-checked only
    for (int i = 0; i < 60; i++) begin
      imem_en = 1'($urandom_range(0, 1)); dmem_en = 1'($urandom_range(0, 1));
      dmem_wen = 1'($urandom_range(0, 1)); dmem_size = 3'($urandom_range(0, 5));
      imem_addr = $urandom; dmem_addr = $urandom; dmem_wdata_delayed = $urandom;
      mem_rdata = $urandom; mem_wait = ($urandom_range(0, 3) == 0);
      mem_badmem_e = ($urandom_range(0, 7) == 0);
      tick();
    end

    imem_en = 1'b0; dmem_en = 1'b0; mem_wait = 1'b0; mem_badmem_e = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vscale_mem_arbiter.md
# vscale_mem_arbiter

Shares one single-ported, two-phase (address then data) memory port between the core's instruction-fetch (imem) and load/store (dmem) interfaces. It sits between `vscale_dpath` and the memory or bus bridge. It grants the dmem side by default, with a bounded-starvation guard for fetch. It tracks the owner of the outstanding data phase and routes read data, write data, wait and bad-memory status back to that owner only.

## Interface
- `DMEM_BURST`, default 4: the maximum number of consecutive accepted dmem grants while imem is pending, after which imem wins once. A value of 0 means strict dmem priority.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_en` in 1: fetch request valid.
- `imem_addr` in 32: fetch address. Held while `imem_wait` is high.
- `imem_rdata` out 32: fetch data. Equals `mem_rdata` when the data-phase owner is imem, else 0.
- `imem_wait` out 1: fetch stalled.
- `imem_badmem_e` out 1: `mem_badmem_e` when the data-phase owner is imem, else 0.
- `dmem_en` in 1: load/store request valid.
- `dmem_wen` in 1: store.
- `dmem_size` in 3: access size, using the codebase encoding.
- `dmem_addr` in 32: access address.
- `dmem_wdata_delayed` in 32: store data, presented in the data phase.
- `dmem_rdata` out 32: load data. Equals `mem_rdata` when the data-phase owner is dmem, else 0.
- `dmem_wait` out 1: load/store stalled.
- `dmem_badmem_e` out 1: `mem_badmem_e` when the data-phase owner is dmem, else 0.
- `mem_en` out 1: address-phase valid.
- `mem_wen` out 1: write.
- `mem_size` out 3: access size.
- `mem_addr` out 32: address.
- `mem_wdata` out 32: write data, driven in the data phase.
- `mem_rdata` in 32: read data.
- `mem_wait` in 1: extends the current data phase.
- `mem_badmem_e` in 1: error, valid in the data phase.

## Operation
- **Registered state.**
  - `owner_q` ∈ {NONE, IMEM, DMEM}: owner of the current data phase.
  - `wen_q`: write flag of the current data phase.
  - `burst_q`: counter, width `$clog2(DMEM_BURST+1)`, minimum 1.
- **Stall.** `stall = mem_wait && owner_q != NONE`. While stalled, no address phase is issued and `mem_en` is 0.
- **Grant, when not stalled.**
  - `force_i = imem_en && DMEM_BURST != 0 && burst_q == DMEM_BURST`.
  - `grant_d = dmem_en && !force_i`.
  - `grant_i = imem_en && !grant_d`.
- **Address-phase mux (combinational).**
  - On `grant_d`: `mem_addr/size/wen` = dmem inputs.
  - On `grant_i`: `mem_addr` = `imem_addr`, `mem_size` = word, `mem_wen` = 0.
  - With no grant: `mem_addr/size/wen` = 0.
  - `mem_en = grant_d || grant_i`.
- **Owner update.** When not stalled, `owner_q` ← DMEM, IMEM or NONE per the grant, and `wen_q` ← `grant_d && dmem_wen`. While stalled, both hold.
- **Burst counter.**
  - On accepted `grant_d` with `imem_en` high: increment, saturating at `DMEM_BURST`.
  - On accepted `grant_i`, or whenever `imem_en` is low: clear to 0.
  - Otherwise: hold.
- **Wait outputs.**
  - `imem_wait = (imem_en && !grant_i) || (owner_q == IMEM && mem_wait)`.
  - `dmem_wait = (dmem_en && !grant_d) || (owner_q == DMEM && mem_wait)`.
  - "Not granted" includes the stalled case, where neither side is granted.
- **Data phase.**
  - `mem_wdata = dmem_wdata_delayed` when `owner_q == DMEM && wen_q`, else 0.
  - Read data and `badmem` are routed only to the owner. Both are 0 to the non-owner and when `owner_q == NONE`.
- **Simultaneous events.**
  - New address issue and previous data-phase completion occur in the same cycle (pipelined). No bubble is inserted.
  - `mem_badmem_e` does not abort or alter arbitration. It is reported only.
- **Reset.**
  - `reset_n` low immediately forces `owner_q` = NONE, `wen_q` = 0, `burst_q` = 0.
  - An in-flight data phase is discarded.
  - All outputs are combinational from this state and the inputs. With `reset_n` low and all requests low, every output is 0.

## Timing
- Zero added latency: an address phase is issued in the same cycle the request is seen.
- Data phase occupies cycle N+1 and is extended by each `mem_wait` cycle.
- Back-to-back accesses: one per cycle, absent `mem_wait`.
- Worst-case fetch starvation with continuous dmem traffic and no `mem_wait`: `DMEM_BURST` cycles.
- Combinational paths:
  - requests → `mem_*` and `*_wait`
  - `mem_wait` → `*_wait` and `mem_en`
  - `mem_rdata` → `*_rdata`

## Structure
- Shared package / `vscale_ctrl_constants.vh` additions:
  - owner encoding: `ARB_OWNER_NONE` = 2'd0, `ARB_OWNER_IMEM` = 2'd1, `ARB_OWNER_DMEM` = 2'd2.
  - word-size constant, reused from the existing memory-size encoding.
- One natural sub-module, `vscale_arb_burst_ctr`: the saturating starvation counter, emitting `force_i`.
- Grant, mux and owner registers live in the top module.

## Test plan
- **Reset.** `reset_n` = 0 mid data phase (owner DMEM, `mem_wait` = 1), then release with both requests low → `owner_q` = NONE and all outputs 0. First post-reset fetch at `0x0` issues `mem_en` = 1, `mem_addr` = 0.
- **Simultaneous requests.** `imem_en` = 1 at `0x100`; `dmem_en` = 1 load at `0x2000`, `mem_rdata` = `0xDEADBEEF`.
  - Cycle N: `mem_addr` = `0x2000`, `imem_wait` = 1.
  - Cycle N+1: `dmem_rdata` = `0xDEADBEEF`, `imem_rdata` = 0, `mem_addr` = `0x100`.
- **Store.** Store to `0x40`, `dmem_wdata_delayed` = `0x12345678`, `mem_wait` high 2 cycles in the data phase.
  - `mem_wdata` = `0x12345678` for 3 cycles.
  - `dmem_wait` = 1 for 2 cycles.
  - `mem_en` = 0 during the stall.
  - A pending fetch issues only after the stall.
- **Starvation guard.** `DMEM_BURST` = 4, `dmem_en` and `imem_en` continuously high → grant pattern D,D,D,D,I repeating. With `DMEM_BURST` = 0 → imem is never granted.
- **Bad memory.** Fetch data phase with `mem_badmem_e` = 1 → `imem_badmem_e` = 1, `dmem_badmem_e` = 0, and the next grant proceeds normally.
- **Back-to-back loads.** Alternating loads and fetches with no wait → one access per cycle, with `owner_q` sequence matching the grant sequence delayed by exactly 1 cycle.
